ravenoc_flit_injector: RTL and testbench
========================================

// Module: ravenoc_flit_injector
// PURPOSE
// - Active transmitter for a router mesh-edge port. Where an unused port is otherwise tied off (req=0, resp=0), this block drives it.
// - Turns a packet command plus a stream of payload words into a head flit, body flits and a tail flit.
// - Issues flits on a router_if-style send channel (valid/fdata/vc_id) and obeys per-VC ready from the router.
// PARAMETERS
// - FLIT_WIDTH  34  flit width: [FLIT_WIDTH-1 -: 2] = type, lower bits = data
// - N_VIRT_CHN  3   number of virtual channels; vc_id width = $clog2(N_VIRT_CHN)
// - X_WIDTH     2   destination-row field width
// - Y_WIDTH     2   destination-column field width
// - PKT_WIDTH   8   pkt_size field width = number of flits following the head
// PORTS
// - clk_noc      in   1                  NoC clock; the only clock
// - arst_noc     in   1                  synchronous, active-high reset
// - cmd_valid    in   1                  packet command valid
// - cmd_ready    out  1                  command accepted when valid&ready
// - cmd_x_dest   in   X_WIDTH            destination row
// - cmd_y_dest   in   Y_WIDTH            destination column
// - cmd_vc       in   $clog2(N_VIRT_CHN) virtual channel for the whole packet
// - cmd_pkt_size in   PKT_WIDTH          flits after the head (0 = head-only packet)
// - cmd_hdr_data in   FLIT_WIDTH-2-X_WIDTH-Y_WIDTH-PKT_WIDTH  head-flit payload
// - dat_valid    in   1                  payload word valid
// - dat_ready    out  1                  payload word consumed when valid&ready
// - dat_word     in   FLIT_WIDTH-2       body/tail payload
// - send_valid   out  1                  flit valid toward router
// - send_fdata   out  FLIT_WIDTH         flit
// - send_vc_id   out  $clog2(N_VIRT_CHN) flit VC
// - recv_ready   in   N_VIRT_CHN         per-VC ready from router
// - busy         out  1                  packet in progress (state != IDLE)
// BEHAVIOUR
// - Flit types: HEAD=2'b00, BODY=2'b01, TAIL=2'b10.
// - Head data field, MSB to LSB: {x_dest, y_dest, pkt_size, hdr_data}.
// - Flit transfer happens when send_valid && recv_ready[send_vc_id].
// - Output stage is a single register. Once send_valid is 1, send_fdata and send_vc_id are held stable until the transfer.
// - FSM states: IDLE, HEAD, BODY, TAIL.
//   - IDLE: cmd_ready=1. On cmd_valid, latch the command (vc, remaining=pkt_size), load the head flit into the output register and set send_valid on the next cycle. Go to HEAD.
//   - HEAD: wait for the head transfer.
//     - pkt_size==0: go to IDLE (no tail).
//     - pkt_size==1: go to TAIL.
//     - otherwise: go to BODY.
//   - BODY/TAIL: dat_ready = (!send_valid || transfer).
//     - A word is loaded as BODY while remaining>1, and as TAIL when remaining==1. Decrement remaining on each load.
//     - When the tail transfers: go to IDLE.
//     - The tail transfer and a new cmd_valid must not overlap. cmd_ready is 1 only in IDLE, so a new head leaves no earlier than 1 cycle after the tail.
// - Throughput: 1 flit/cycle when recv_ready is held high and dat_valid is held high. Head latency = 1 cycle from command acceptance.
// - dat_valid low mid-packet: send_valid drops to 0 after the pending flit transfers. The FSM stays in its state; no bubble flit is emitted.
// - recv_ready for VCs other than send_vc_id is ignored.
// - VC stays fixed for the whole packet.
// - pkt_size wraps at PKT_WIDTH bits; the maximum packet is 2^PKT_WIDTH flits including the head.
// - Reset values: cmd_ready=0 during reset and 1 after it; dat_ready=0; send_valid=0; send_fdata=0; send_vc_id=0; busy=0; FSM=IDLE; remaining=0.
// - Reset mid-packet aborts immediately. The partial packet is dropped and send_valid=0 on the next cycle. The router is not notified.
// CONFIGURATION
// - Macro RAVENOC_INJ_STATS_EN, when defined, adds:
//   - out  pkt_cnt  [31:0]: +1 on each tail transfer, and on head transfer when pkt_size==0.
//   - out  flit_cnt [31:0]: +1 on every flit transfer.
//   - Both counters reset to 0 and wrap modulo 2^32.
// - Without the macro: these ports and registers do not exist; behaviour is otherwise identical.
// TESTING
// - Reset, then cmd x=1 y=2 vc=0 size=0 hdr=0xABC, recv_ready=3'b111 -> one flit, type 00, x=1, y=2, size=0; back to IDLE; cmd_ready=1 next cycle.
// - size=3, vc=1, words 0x11/0x22/0x33 streamed, ready high -> HEAD,BODY(0x11),BODY(0x22),TAIL(0x33) on 4 consecutive cycles; all send_vc_id=1.
// - size=2, vc=2, recv_ready[2]=0 for 5 cycles with recv_ready[0]=1 -> head held stable for 5 cycles, no transfer, dat_ready=0; then head, body, tail.
// - size=4 with dat_valid toggled 1,0,0,1,1,0,1 -> flits emitted only for valid words; payload order preserved; no duplicate or bubble flits.
// - Reset asserted after the 2nd flit of a size=5 packet -> send_valid=0 next cycle, busy=0; a new size=1 packet then goes out cleanly as HEAD,TAIL.
// - RAVENOC_INJ_STATS_EN defined: packets of size 0, 1, 3 -> pkt_cnt=3, flit_cnt=7.

Source files
------------

// File: rtl/ravenoc_flit_injector.sv
// rtl/ravenoc_flit_injector.sv - turns packet commands plus payload words into head/body/tail flits
// Optional RAVENOC_INJ_STATS_EN adds pkt_cnt/flit_cnt transfer counters.
module ravenoc_flit_injector #(
  parameter int  FLIT_WIDTH = 34,
  parameter int  N_VIRT_CHN = 3,
  parameter int  X_WIDTH    = 2,
  parameter int  Y_WIDTH    = 2,
  parameter int  PKT_WIDTH  = 8,
  localparam int VC_WIDTH   = $clog2(N_VIRT_CHN),
  localparam int HDR_WIDTH  = FLIT_WIDTH - 2 - X_WIDTH - Y_WIDTH - PKT_WIDTH,
  localparam int DAT_WIDTH  = FLIT_WIDTH - 2
) (
  input  logic                  clk_noc,
  input  logic                  arst_noc,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_WIDTH-1:0]    cmd_x_dest,
  input  logic [Y_WIDTH-1:0]    cmd_y_dest,
  input  logic [VC_WIDTH-1:0]   cmd_vc,
  input  logic [PKT_WIDTH-1:0]  cmd_pkt_size,
  input  logic [HDR_WIDTH-1:0]  cmd_hdr_data,
  input  logic                  dat_valid,
  output logic                  dat_ready,
  input  logic [DAT_WIDTH-1:0]  dat_word,
  output logic                  send_valid,
  output logic [FLIT_WIDTH-1:0] send_fdata,
  output logic [VC_WIDTH-1:0]   send_vc_id,
  input  logic [N_VIRT_CHN-1:0] recv_ready,
  output logic                  busy
`ifdef RAVENOC_INJ_STATS_EN
  ,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           flit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  state_t               state, state_nxt;
  logic [PKT_WIDTH-1:0] remaining;
  logic                 transfer;
  logic                 accept;
  logic                 load;
  logic [1:0]           load_type;

  assign transfer  = send_valid && recv_ready[send_vc_id];
  assign accept    = cmd_valid && cmd_ready;
  assign load      = dat_valid && dat_ready;
  assign load_type = (remaining == PKT_WIDTH'(1)) ? TYPE_TAIL : TYPE_BODY;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_noc) begin
    if (arst_noc) state <= IDLE;
    else          state <= state_nxt;
  end

  // remaining counts payload words not yet loaded; 0 in TAIL means the tail sits in the output register
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    dat_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = HEAD;
      end
      HEAD: begin
        if (transfer) begin
          if (remaining == '0) begin
            state_nxt = IDLE;
          end else begin
            dat_ready = 1'b1;
            state_nxt = (remaining == PKT_WIDTH'(1)) ? TAIL : BODY;
          end
        end
      end
      BODY: begin
        dat_ready = !send_valid || transfer;
        if (dat_valid && (!send_valid || transfer) && (remaining <= PKT_WIDTH'(2)))
          state_nxt = TAIL;
      end
      TAIL: begin
        dat_ready = (remaining != '0) && (!send_valid || transfer);
        if (transfer && (remaining == '0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (arst_noc) begin
      cmd_ready = 1'b0;
      dat_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (arst_noc) begin
      send_valid <= 1'b0;
      send_fdata <= '0;
      send_vc_id <= '0;
      remaining  <= '0;
    end else if (accept) begin
      send_valid <= 1'b1;
      send_fdata <= {TYPE_HEAD, cmd_x_dest, cmd_y_dest, cmd_pkt_size, cmd_hdr_data};
      send_vc_id <= cmd_vc;
      remaining  <= cmd_pkt_size;
    end else if (load) begin
      send_valid <= 1'b1;
      send_fdata <= {load_type, dat_word};
      remaining  <= remaining - PKT_WIDTH'(1);
    end else if (transfer) begin
      send_valid <= 1'b0;
    end
  end

`ifdef RAVENOC_INJ_STATS_EN
  logic pkt_done;

  assign pkt_done = transfer && (remaining == '0) && ((state == HEAD) || (state == TAIL));

  always_ff @(posedge clk_noc) begin
    if (arst_noc) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else begin
      if (pkt_done) pkt_cnt  <= pkt_cnt + 32'd1;
      if (transfer) flit_cnt <= flit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ravenoc_flit_injector.sv
// tb/tb_ravenoc_flit_injector.sv - randomized scoreboard bench for ravenoc_flit_injector
module tb_ravenoc_flit_injector;

  typedef struct packed {
    logic [33:0] fdata;
    logic [1:0]  vc;
  } flit_t;

  logic        clk = 1'b0;
  logic        arst_noc;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_x_dest;
  logic [1:0]  cmd_y_dest;
  logic [1:0]  cmd_vc;
  logic [7:0]  cmd_pkt_size;
  logic [19:0] cmd_hdr_data;
  logic        dat_valid;
  logic        dat_ready;
  logic [31:0] dat_word;
  logic        send_valid;
  logic [33:0] send_fdata;
  logic [1:0]  send_vc_id;
  logic [2:0]  recv_ready;
  logic        busy;
`ifdef RAVENOC_INJ_STATS_EN
  logic [31:0] pkt_cnt;
  logic [31:0] flit_cnt;
`endif

  int          n_checks = 0;
  int          n_pass = 0;
  flit_t       exp_q[$];
  logic [31:0] preset[$];
  int          mdl_pkts = 0;
  int          mdl_flits = 0;

  always #5 clk = ~clk;

  ravenoc_flit_injector dut (
    .clk_noc      (clk),
    .arst_noc     (arst_noc),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x_dest   (cmd_x_dest),
    .cmd_y_dest   (cmd_y_dest),
    .cmd_vc       (cmd_vc),
    .cmd_pkt_size (cmd_pkt_size),
    .cmd_hdr_data (cmd_hdr_data),
    .dat_valid    (dat_valid),
    .dat_ready    (dat_ready),
    .dat_word     (dat_word),
    .send_valid   (send_valid),
    .send_fdata   (send_fdata),
    .send_vc_id   (send_vc_id),
    .recv_ready   (recv_ready),
    .busy         (busy)
`ifdef RAVENOC_INJ_STATS_EN
    ,
    .pkt_cnt      (pkt_cnt),
    .flit_cnt     (flit_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every accepted flit must be the next expected one; a waiting flit must not change
  bit          have_prev = 0;
  logic [35:0] prev_flit;
  always @(negedge clk) begin
    flit_t e;
    if (arst_noc) begin
      have_prev = 0;
    end else begin
      if (have_prev) begin
        chk("hold_vld", send_valid, 1);
        chk("hold_data", {send_vc_id, send_fdata}, prev_flit);
      end
      if (send_valid && recv_ready[send_vc_id]) begin
        have_prev = 0;
        chk("flit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fdata", send_fdata, e.fdata);
          chk("vc", send_vc_id, e.vc);
        end
      end else if (send_valid) begin
        have_prev = 1;
        prev_flit = {send_vc_id, send_fdata};
      end else begin
        have_prev = 0;
      end
    end
  end

  // vmode: 0 dat_valid high, 1 random, 2 pattern 1,0,0,1,1,0,1; rrm: 0 ready high, 1 random
  task automatic run_pkt(input logic [1:0] x, input logic [1:0] y, input logic [1:0] vc,
                         input logic [7:0] size, input logic [19:0] hdr,
                         input int stall, input int vmode, input int rrm);
    logic [31:0] words[$];
    logic [6:0]  pat;
    int          i, cyc;
    bit          acc, done;
    pat = 7'b1011001;
    words = preset;
    preset.delete();
    while (words.size() < int'(size)) words.push_back($urandom);
    exp_q.push_back('{fdata: {2'b00, x, y, size, hdr}, vc: vc});
    for (int k = 0; k < int'(size); k++)
      exp_q.push_back('{fdata: {((k == int'(size) - 1) ? 2'b10 : 2'b01), words[k]}, vc: vc});

    cmd_valid = 1'b1; cmd_x_dest = x; cmd_y_dest = y; cmd_vc = vc;
    cmd_pkt_size = size; cmd_hdr_data = hdr; dat_valid = 1'b0;
    recv_ready = (rrm != 0) ? 3'($urandom_range(0, 7)) : 3'b111;
    acc = 0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    chk("cmd_acc", acc, 1);
    cmd_valid = 1'b0;

    i = 0; cyc = 0; done = 0;
    while (!done && cyc < 4000) begin
      if (cyc < stall) recv_ready = 3'b111 & ~(3'b001 << vc);
      else recv_ready = (rrm != 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      dat_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'($urandom_range(0, 1)) : pat[cyc % 7];
      dat_word  = (i < int'(size)) ? words[i] : $urandom;
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("head_lat", send_valid, 1);
      if (cyc <= stall) begin
        chk("stall_dat_rdy", dat_ready, 0);
        chk("stall_vld", send_valid, 1);
      end
      if (dat_valid && dat_ready) i++;
      done = (i >= int'(size)) && !busy;
      @(posedge clk); #1;
    end
    dat_valid = 1'b0;
    chk("pkt_done", done, 1);
    chk("drained", exp_q.size(), 0);
    chk("idle_rdy", cmd_ready, 1);
    if (vmode == 0 && rrm == 0 && stall == 0) chk("thruput", cyc, int'(size) + 2);
    mdl_pkts++;
    mdl_flits += int'(size) + 1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cmd_rdy"}, cmd_ready, 0);
    chk({tag, "_dat_rdy"}, dat_ready, 0);
    chk({tag, "_vld"}, send_valid, 0);
    chk({tag, "_fdata"}, send_fdata, 0);
    chk({tag, "_vc"}, send_vc_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] w[5];
    int          i, nx;
    arst_noc = 1'b1; cmd_valid = 1'b0; cmd_x_dest = '0; cmd_y_dest = '0; cmd_vc = '0;
    cmd_pkt_size = '0; cmd_hdr_data = '0; dat_valid = 1'b0; dat_word = '0; recv_ready = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk); #1;
    arst_noc = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", cmd_ready, 1);
    @(posedge clk); #1;

    run_pkt(2'd1, 2'd2, 2'd0, 8'd0, 20'hABC, 0, 0, 0);
    preset = '{32'h11, 32'h22, 32'h33};
    run_pkt(2'd0, 2'd3, 2'd1, 8'd3, 20'h5A5A5, 0, 0, 0);
    run_pkt(2'd2, 2'd1, 2'd2, 8'd2, 20'h00F0F, 5, 0, 0);
    run_pkt(2'd3, 2'd3, 2'd1, 8'd4, 20'h13579, 0, 2, 0);
    run_pkt(2'd3, 2'd0, 2'd2, 8'd255, 20'hFFFFF, 0, 0, 0);

    for (int k = 0; k < 5; k++) w[k] = $urandom;
    exp_q.push_back('{fdata: {2'b00, 2'd3, 2'd0, 8'd5, 20'h12345}, vc: 2'd0});
    exp_q.push_back('{fdata: {2'b01, w[0]}, vc: 2'd0});
    cmd_valid = 1'b1; cmd_x_dest = 2'd3; cmd_y_dest = 2'd0; cmd_vc = 2'd0;
    cmd_pkt_size = 8'd5; cmd_hdr_data = 20'h12345;
    recv_ready = 3'b111; dat_valid = 1'b1; dat_word = w[0];
    i = 0; nx = 0;
    for (int t = 0; t < 20 && nx < 2; t++) begin
      @(negedge clk);
      if (send_valid && recv_ready[send_vc_id]) nx++;
      if (dat_valid && dat_ready) i++;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      dat_word = w[i % 5];
    end
    chk("rst_two_flits", nx, 2);
    arst_noc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("abort");
    exp_q.delete();
    mdl_pkts = 0;
    mdl_flits = 0;
    dat_valid = 1'b0;
    @(posedge clk); #1;
    arst_noc = 1'b0;
    @(negedge clk);
    chk("rdy_after_abort", cmd_ready, 1);
    @(posedge clk); #1;

    run_pkt(2'd1, 2'd1, 2'd1, 8'd1, 20'h0BEEF, 0, 0, 0);
    run_pkt(2'd2, 2'd2, 2'd0, 8'd0, 20'h00001, 0, 1, 1);
    run_pkt(2'd0, 2'd1, 2'd2, 8'd3, 20'h54321, 0, 1, 1);
`ifdef RAVENOC_INJ_STATS_EN
    chk("pkt_cnt_013", pkt_cnt, 3);
    chk("flit_cnt_013", flit_cnt, 7);
`endif

    for (int p = 0; p < 25; p++)
      run_pkt(2'($urandom), 2'($urandom), 2'($urandom_range(0, 2)),
              8'($urandom_range(0, 12)), 20'($urandom), 0, 1, 1);

`ifdef RAVENOC_INJ_STATS_EN
    chk("pkt_cnt_final", pkt_cnt, mdl_pkts);
    chk("flit_cnt_final", flit_cnt, mdl_flits);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
